// File: rtl/arm_control_unit_if.sv
// Control/status bundle between the ARM-subset datapath and its control unit.
// Instruction fields, live ALU flags and run-control requests flow in; decoded controls flow out.
// Optional RETIRE_COUNT_EN adds the retired-instruction counter to the bundle.
interface arm_control_unit_if;
   // datapath / debugger -> control unit
   logic [3:0]  cond;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  rd;
   logic [3:0]  alu_flags;
   logic        halt_req;
   logic        resume;
   logic        step;
   // control unit -> datapath
   logic        pc_src;
   logic        mem_to_reg;
   logic        mem_write;
   logic        alu_src;
   logic        imm_src;
   logic        reg_write;
   logic        shift;
   logic        reg_src;
   logic [2:0]  alu_control;
   logic        pc_en;
   logic [3:0]  flags;
   logic        halted;
`ifdef RETIRE_COUNT_EN
   logic [31:0] retired_count;
`endif

   // datapath side
   modport master (
      output cond, op, funct, rd, alu_flags, halt_req, resume, step,
      input  pc_src, mem_to_reg, mem_write, alu_src, imm_src, reg_write,
             shift, reg_src, alu_control, pc_en, flags, halted
`ifdef RETIRE_COUNT_EN
      , input retired_count
`endif
   );

   // control unit side
   modport slave (
      input  cond, op, funct, rd, alu_flags, halt_req, resume, step,
      output pc_src, mem_to_reg, mem_write, alu_src, imm_src, reg_write,
             shift, reg_src, alu_control, pc_en, flags, halted
`ifdef RETIRE_COUNT_EN
      , output retired_count
`endif
   );
endinterface

// File: rtl/arm_control_unit.sv
// Decoder, NZCV flags register and run FSM (HOLD/RUN/HALT/STEP) for the single-cycle ARM-subset datapath.
// Latency: decode and strobes are combinational; flags and run state update on the next rising edge.
// No backpressure: halt/resume/step requests are sampled every cycle; optional RETIRE_COUNT_EN adds a retire counter.
module arm_control_unit #(
   parameter int HOLD_CYCLES  = 2,
   parameter int START_HALTED = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   arm_control_unit_if.slave    bus
);

   typedef enum logic [1:0] {S_HOLD, S_RUN, S_HALT, S_STEP} state_t;

   localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] COND_HALT = 4'b1111;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;

   state_t      state, state_nxt;
   logic [3:0]  hold_cnt;
   logic        exec;
   logic        cond_ex;
   logic [3:0]  flags_q;

   // raw decode results before conditional/run gating
   logic        dec_reg_write;
   logic        dec_mem_write;
   logic        dec_branch;
   logic        dec_flag_wr;
   logic        dec_mem_to_reg;
   logic        dec_alu_src;
   logic        dec_imm_src;
   logic        dec_shift;
   logic        dec_reg_src;
   logic [2:0]  dec_alu_control;
   logic        dec_pc_src;

   logic [3:0]  cmd;
   logic        s_bit;
   logic        n_f, z_f, c_f, v_f;

   assign cmd   = bus.funct[4:1];
   assign s_bit = bus.funct[0];
   assign {n_f, z_f, c_f, v_f} = flags_q;

   // Instruction decode: datapath controls from Op/Funct, independent of run state and condition.
   always_comb begin
      dec_reg_write   = 1'b0;
      dec_mem_write   = 1'b0;
      dec_branch      = 1'b0;
      dec_flag_wr     = 1'b0;
      dec_mem_to_reg  = 1'b0;
      dec_alu_src     = 1'b0;
      dec_imm_src     = 1'b0;
      dec_shift       = 1'b0;
      dec_reg_src     = 1'b0;
      dec_alu_control = ALU_ADD;
      case (bus.op)
         2'b00: begin
            dec_alu_src = bus.funct[5];
            dec_imm_src = bus.funct[5];
            case (cmd)
               CMD_ADD: begin dec_alu_control = ALU_ADD; dec_reg_write = 1'b1; dec_flag_wr = s_bit; end
               CMD_SUB: begin dec_alu_control = ALU_SUB; dec_reg_write = 1'b1; dec_flag_wr = s_bit; end
               CMD_AND: begin dec_alu_control = ALU_AND; dec_reg_write = 1'b1; dec_flag_wr = s_bit; end
               CMD_ORR: begin dec_alu_control = ALU_ORR; dec_reg_write = 1'b1; dec_flag_wr = s_bit; end
               // compare: subtract for flags only, S bit irrelevant
               CMD_CMP: begin dec_alu_control = ALU_SUB; dec_flag_wr = 1'b1; end
               // move: operand routed around the ALU through the shifter path
               CMD_MOV: begin dec_shift = 1'b1; dec_reg_write = 1'b1; dec_flag_wr = s_bit; end
               default: ;
            endcase
         end
         2'b01: begin
            dec_alu_src    = 1'b1;
            dec_reg_src    = 1'b1;
            dec_mem_to_reg = s_bit;
            dec_reg_write  = s_bit;
            dec_mem_write  = ~s_bit;
         end
         2'b10: begin
            dec_alu_src = 1'b1;
            dec_imm_src = 1'b1;
            dec_branch  = 1'b1;
         end
         default: ;
      endcase
      dec_pc_src = dec_branch | (dec_reg_write & (bus.rd == 4'b1111));
   end

   // Condition check against the architectural (registered) flags; 1111 is the halt encoding.
   always_comb begin
      cond_ex = 1'b0;
      case (bus.cond)
         4'b0000: cond_ex = z_f;
         4'b0001: cond_ex = ~z_f;
         4'b0010: cond_ex = c_f;
         4'b0011: cond_ex = ~c_f;
         4'b0100: cond_ex = n_f;
         4'b0101: cond_ex = ~n_f;
         4'b0110: cond_ex = v_f;
         4'b0111: cond_ex = ~v_f;
         4'b1000: cond_ex = c_f & ~z_f;
         4'b1001: cond_ex = ~c_f | z_f;
         4'b1010: cond_ex = (n_f == v_f);
         4'b1011: cond_ex = (n_f != v_f);
         4'b1100: cond_ex = ~z_f & (n_f == v_f);
         4'b1101: cond_ex = z_f | (n_f != v_f);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Run state register and post-reset hold countdown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_HOLD;
         hold_cnt <= HOLD_INIT;
      end else begin
         state <= state_nxt;
         if (state == S_HOLD && hold_cnt != 4'd0)
            hold_cnt <= hold_cnt - 4'd1;
      end
   end

   // Run state transitions; in HALT a held halt request outranks resume, which outranks step.
   always_comb begin
      state_nxt = state;
      case (state)
         S_HOLD: if (hold_cnt == 4'd0) state_nxt = (START_HALTED != 0) ? S_HALT : S_RUN;
         S_RUN:  if (bus.halt_req || bus.cond == COND_HALT) state_nxt = S_HALT;
         S_HALT: begin
            if (bus.halt_req)    state_nxt = S_HALT;
            else if (bus.resume) state_nxt = S_RUN;
            else if (bus.step)   state_nxt = S_STEP;
         end
         S_STEP: state_nxt = S_HALT;
         default: state_nxt = S_HOLD;
      endcase
   end

   // Run state outputs: the instruction on the pins executes only in RUN (unless this cycle halts) or STEP.
   always_comb begin
      exec       = 1'b0;
      bus.halted = 1'b0;
      case (state)
         S_RUN:  exec = ~(bus.halt_req | (bus.cond == COND_HALT));
         S_STEP: exec = 1'b1;
         S_HALT: bus.halted = 1'b1;
         default: ;
      endcase
   end

   // Architectural NZCV: loads only for executed, condition-passing flag-setting data-processing ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         flags_q <= 4'b0000;
      else if (exec && cond_ex && dec_flag_wr)
         flags_q <= bus.alu_flags;
   end

`ifdef RETIRE_COUNT_EN
   logic [31:0] retired_q;

   // Retired-instruction counter; free-running wrap at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retired_q <= 32'd0;
      else if (exec && cond_ex)
         retired_q <= retired_q + 32'd1;
   end

   assign bus.retired_count = retired_q;
`endif

   // State-changing strobes drop combinationally with exec so reset or halt never leaks a write.
   assign bus.reg_write   = dec_reg_write & cond_ex & exec;
   assign bus.mem_write   = dec_mem_write & cond_ex & exec;
   assign bus.pc_src      = dec_pc_src    & cond_ex & exec;
   assign bus.mem_to_reg  = dec_mem_to_reg;
   assign bus.alu_src     = dec_alu_src;
   assign bus.imm_src     = dec_imm_src;
   assign bus.shift       = dec_shift;
   assign bus.reg_src     = dec_reg_src;
   assign bus.alu_control = dec_alu_control;
   assign bus.pc_en       = exec;
   assign bus.flags       = flags_q;

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed bench for arm_control_unit: reset/hold timing, decode, conditional execution and run control.
// Inputs change 1 ns after a rising edge and outputs are sampled 1 ns later, away from the edge.
// Each check is an immediate assertion; failures are counted and reported, then a single summary line prints.
module tb_arm_control_unit;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   arm_control_unit_if bus ();

   arm_control_unit #(.HOLD_CYCLES(2), .START_HALTED(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
      bus.cond  = c;
      bus.op    = o;
      bus.funct = f;
      bus.rd    = r;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.halt_req = 1'b0;
      bus.resume   = 1'b0;
      bus.step     = 1'b0;
      bus.alu_flags = 4'b0000;
      set_instr(4'b1110, 2'b11, 6'b000000, 4'd0);
      #2;
      chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
      chk("rst_flags", 32'(bus.flags), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);

      // release reset between edges; two HOLD cycles then RUN
      tick();
      rst_n = 1'b1;
      #1;
      chk("hold1_pc_en", 32'(bus.pc_en), 32'd0);
      tick();
      chk("hold2_pc_en", 32'(bus.pc_en), 32'd0);
      chk("hold2_halted", 32'(bus.halted), 32'd0);
      tick();
      chk("run_pc_en", 32'(bus.pc_en), 32'd1);
      chk("run_flags", 32'(bus.flags), 32'd0);

      // SUBS R1,R1,R1 with ALU flags Z,C
      set_instr(4'b1110, 2'b00, 6'b000101, 4'd1);
      bus.alu_flags = 4'b0110;
      #1;
      chk("subs_reg_write", 32'(bus.reg_write), 32'd1);
      chk("subs_alu_ctl", 32'(bus.alu_control), 32'd1);
      tick();
      chk("subs_flags", 32'(bus.flags), 32'h6);

      // ADDEQ passes (Z=1), ADDNE fails
      bus.alu_flags = 4'b0000;
      set_instr(4'b0000, 2'b00, 6'b001000, 4'd2);
      #1;
      chk("addeq_reg_write", 32'(bus.reg_write), 32'd1);
      chk("addeq_alu_ctl", 32'(bus.alu_control), 32'd0);
      set_instr(4'b0001, 2'b00, 6'b001000, 4'd2);
      #1;
      chk("addne_reg_write", 32'(bus.reg_write), 32'd0);
      chk("addne_pc_en", 32'(bus.pc_en), 32'd1);
      tick();
      chk("addne_flags_kept", 32'(bus.flags), 32'h6);

      // CMP: SUB, no register write, flags written even with S=0
      set_instr(4'b1110, 2'b00, 6'b010100, 4'd0);
      bus.alu_flags = 4'b1000;
      #1;
      chk("cmp_reg_write", 32'(bus.reg_write), 32'd0);
      chk("cmp_alu_ctl", 32'(bus.alu_control), 32'd1);
      tick();
      chk("cmp_flags", 32'(bus.flags), 32'h8);

      // ADD without S must not touch flags; Rd=PC redirects
      bus.alu_flags = 4'b0101;
      set_instr(4'b1110, 2'b00, 6'b001000, 4'hF);
      #1;
      chk("addpc_pc_src", 32'(bus.pc_src), 32'd1);
      chk("addpc_reg_write", 32'(bus.reg_write), 32'd1);
      tick();
      chk("add_nos_flags", 32'(bus.flags), 32'h8);

      // LDR / STR
      set_instr(4'b1110, 2'b01, 6'b000001, 4'd3);
      #1;
      chk("ldr_ctl", {28'd0, bus.mem_to_reg, bus.reg_write, bus.reg_src, bus.alu_src}, 32'hF);
      chk("ldr_mem_write", 32'(bus.mem_write), 32'd0);
      chk("ldr_imm_src", 32'(bus.imm_src), 32'd0);
      set_instr(4'b1110, 2'b01, 6'b000000, 4'd3);
      #1;
      chk("str_mem_write", 32'(bus.mem_write), 32'd1);
      chk("str_reg_write", 32'(bus.reg_write), 32'd0);

      // branch and MOV immediate
      set_instr(4'b1110, 2'b10, 6'b000000, 4'd0);
      #1;
      chk("b_ctl", {28'd0, bus.pc_src, bus.imm_src, bus.alu_src, bus.reg_write}, 32'hE);
      set_instr(4'b1110, 2'b00, 6'b111010, 4'd4);
      #1;
      chk("mov_ctl", {28'd0, bus.shift, bus.alu_src, bus.imm_src, bus.reg_write}, 32'hF);

      // halt instruction in RUN
      set_instr(4'b1111, 2'b00, 6'b001000, 4'd1);
      #1;
      chk("hlt_pc_en", 32'(bus.pc_en), 32'd0);
      chk("hlt_strobes", {29'd0, bus.reg_write, bus.mem_write, bus.pc_src}, 32'd0);
      tick();
      chk("hlt_halted", 32'(bus.halted), 32'd1);
      chk("hlt_pc_en2", 32'(bus.pc_en), 32'd0);

      // single step one ADD
      set_instr(4'b1110, 2'b00, 6'b001000, 4'd5);
      bus.step = 1'b1;
      #1;
      chk("halt_no_exec", 32'(bus.reg_write), 32'd0);
      tick();
      bus.step = 1'b0;
      #1;
      chk("step_pc_en", 32'(bus.pc_en), 32'd1);
      chk("step_reg_write", 32'(bus.reg_write), 32'd1);
      chk("step_halted", 32'(bus.halted), 32'd0);
      tick();
      chk("step_back_halted", 32'(bus.halted), 32'd1);
      chk("step_back_pc_en", 32'(bus.pc_en), 32'd0);

      // halt request outranks resume
      bus.halt_req = 1'b1;
      bus.resume   = 1'b1;
      tick();
      chk("hreq_res_halted", 32'(bus.halted), 32'd1);
      bus.halt_req = 1'b0;
      tick();
      bus.resume = 1'b0;
      #1;
      chk("resume_halted", 32'(bus.halted), 32'd0);
      chk("resume_pc_en", 32'(bus.pc_en), 32'd1);

      // halt request from RUN blocks the current instruction
      bus.halt_req = 1'b1;
      #1;
      chk("hreq_run_pc_en", 32'(bus.pc_en), 32'd0);
      chk("hreq_run_reg_write", 32'(bus.reg_write), 32'd0);
      tick();
      chk("hreq_run_halted", 32'(bus.halted), 32'd1);
      bus.halt_req = 1'b0;
      bus.resume   = 1'b1;
      tick();
      bus.resume = 1'b0;

      // reset asserted during a STR cycle
      set_instr(4'b1110, 2'b01, 6'b000000, 4'd3);
      #1;
      chk("pre_rst_mem_write", 32'(bus.mem_write), 32'd1);
      chk("pre_rst_flags", 32'(bus.flags), 32'h8);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_write", 32'(bus.mem_write), 32'd0);
      chk("midrst_flags", 32'(bus.flags), 32'd0);
      chk("midrst_pc_en", 32'(bus.pc_en), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rehold1_pc_en", 32'(bus.pc_en), 32'd0);
      tick();
      chk("rehold2_pc_en", 32'(bus.pc_en), 32'd0);
      tick();
      chk("rerun_pc_en", 32'(bus.pc_en), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arm_control_unit.md
Name: arm_control_unit

Overview:
Control unit and run controller for the single-cycle ARM-subset datapath. It decodes Cond/Op/Funct/Rd into the datapath control signals and holds the architectural NZCV flags register for conditional execution. A small run FSM (post-reset hold, run, halt, single-step) gates all state-changing strobes and drives a PC enable. It sits beside the datapath and connects one-to-one to its control and status pins.

Parameters:
HOLD_CYCLES, 2, cycles spent in HOLD after reset release before fetch starts (1..15).
START_HALTED, 0, 1 = enter HALT instead of RUN after HOLD.

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
Cond  input  4  Inst[31:28].
Op  input  2  Inst[27:26].
Funct  input  6  Inst[25:20]; [5]=I, [4:1]=cmd, [0]=S/L.
Rd  input  4  Inst[15:12].
ALUFlags  input  4  live ALU flags {N,Z,C,V}.
Halt_Req  input  1  level; request halt at the next instruction boundary.
Resume  input  1  pulse; leave HALT into RUN.
Step  input  1  pulse; execute exactly one instruction from HALT.
PCSrc, MemtoReg, MemWrite, ALUSrc, ImmSrc, RegWrite, Shift, RegSrc  output  1 each  datapath controls.
ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR.
PCEn  output  1  PC register load enable.
Flags  output  4  registered {N,Z,C,V}.
Halted  output  1  high in HALT.

Behaviour:
- Decode is combinational. Op=00 data-processing: cmd 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no register write, flags always written), 1101 MOV (Shift=1, ALU bypass). ALUSrc=ImmSrc=Funct[5]. RegSrc=0. Unlisted cmd: all write strobes 0.
- Op=01 memory: ALUSrc=1, ImmSrc=0, ADD, RegSrc=1. Funct[0]=1 LDR (MemtoReg=1, RegWrite=1); Funct[0]=0 STR (MemWrite=1).
- Op=10 branch: ALUSrc=1, ImmSrc=1, ADD, PCSrc=1, RegWrite=0. Op=11: no-op.
- PCSrc also 1 for any register write with Rd=1111.
- CondEx is evaluated against registered Flags with ARM semantics for 0000..1110 (1110 = always). Cond=1111 is HALT: no writes, FSM enters HALT; PC does not advance past it.
- Effective RegWrite/MemWrite/PCSrc = decoded AND CondEx AND exec, with exec = 1 only in RUN or STEP.
- Flags register: loads ALUFlags on the rising edge when exec AND CondEx AND Op=00 AND (S=1 or CMP). Reset value 0000.
- FSM states: HOLD, RUN, HALT, STEP. Reset -> HOLD; counter loads HOLD_CYCLES-1 and counts down to 0, then -> RUN (or HALT if START_HALTED=1).
- RUN: Halt_Req=1 or Cond=1111 -> HALT; that instruction does not execute. Otherwise stay.
- HALT: priority Halt_Req > Resume > Step. Resume -> RUN; Step -> STEP; else stay.
- STEP: exactly one cycle; the instruction executes, then -> HALT unconditionally. Cond=1111 in STEP executes as a no-op.
- PCEn = 1 only in RUN (excluding the halting cycle) and in STEP.
- Reset values: all strobes 0, PCEn 0, Flags 0000, Halted 0 (state HOLD).
- Reset asserted mid-instruction: immediate asynchronous return to HOLD. No partial writes leave the block, because strobes drop combinationally with exec.

Optional Feature:
RETIRE_COUNT_EN: adds a 32-bit output Retired_Count that increments on every cycle with exec=1 and CondEx=1. It wraps from FFFFFFFF to 0 and resets to 0. Without the macro the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Release reset with HOLD_CYCLES=2 -> PCEn 0 for 2 cycles, then 1. Flags=0000, Halted=0.
- SUBS R1,R1,R1 (Op=00, cmd=0010, S=1) with ALUFlags=0110 -> Flags=0110 next edge. Following ADDEQ writes (RegWrite=1); ADDNE gives RegWrite=0.
- LDR (Op=01, Funct[0]=1, Rd=0011) -> MemtoReg=1, RegWrite=1, RegSrc=1, ALUSrc=1. STR -> MemWrite=1, RegWrite=0.
- Instruction with Cond=1111 in RUN -> Halted=1, PCEn=0, all strobes 0. Step pulse -> one cycle PCEn=1 with strobes active, then Halted=1 again.
- Halt_Req and Resume asserted together in HALT -> remains HALT. Resume alone -> RUN next cycle.
- Reset pulled low during a STR cycle -> MemWrite drops to 0 immediately; Flags=0000; FSM returns to HOLD.
